// File: rtl/run_ctrl_scheduler.sv
// Run-control sequencer for the gated task clock: turns host halt/run/step/run-to
// commands into clk_en and breakpoint, and owns the task-cycle counter and halt cause.
module run_ctrl_scheduler #(
  parameter int CNT_W = 64
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             difftest_break,
  output logic             clk_en,
  output logic [CNT_W-1:0] breakpoint,
  output logic             running,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] task_cycles,
  output logic             done,
  output logic             cmd_err
);

  typedef enum logic [0:0] {
    ST_HALTED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam logic [1:0] OP_HALT   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_RUN_TO = 2'd3;

  localparam logic [1:0] CAUSE_RESET  = 2'd0;
  localparam logic [1:0] CAUSE_HOST   = 2'd1;
  localparam logic [1:0] CAUSE_TARGET = 2'd2;
  localparam logic [1:0] CAUSE_DIFF   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_s;
  logic             bounded_r, bounded_s;
  logic             clk_en_r;
  logic [CNT_W-1:0] bp_r, bp_s;
  logic [CNT_W-1:0] tc_r;
  logic [1:0]       cause_r, cause_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  logic [CNT_W:0]   step_sum_s;
  logic [CNT_W-1:0] tc_inc_s;
  logic             target_hit_s;
  logic             is_start_s;
  logic             host_halt_s;

  // Carry out of the sum marks a STEP that would overflow the counter.
  assign step_sum_s   = {1'b0, tc_r} + {1'b0, cmd_arg};
  assign tc_inc_s     = tc_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign target_hit_s = bounded_r && (tc_inc_s == bp_r);
  assign is_start_s   = cmd_valid && (cmd_op != OP_HALT);
  assign host_halt_s  = cmd_valid && (cmd_op == OP_HALT);

  // Next-state, stop arbitration and command acceptance.
  always_comb begin
    state_s   = state_r;
    bounded_s = bounded_r;
    bp_s      = bp_r;
    cause_s   = cause_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      ST_HALTED: begin
        if (is_start_s) begin
          if (difftest_break) begin
            err_s = 1'b1;
          end else begin
            case (cmd_op)
              OP_RUN: begin
                state_s   = ST_RUNNING;
                bounded_s = 1'b0;
                bp_s      = CNT_ONES;
              end
              OP_STEP: begin
                if (cmd_arg == CNT_ZERO) begin
                  done_s = 1'b1;
                end else if (step_sum_s[CNT_W]) begin
                  err_s = 1'b1;
                end else begin
                  state_s   = ST_RUNNING;
                  bounded_s = 1'b1;
                  bp_s      = step_sum_s[CNT_W-1:0];
                end
              end
              OP_RUN_TO: begin
                if (cmd_arg <= tc_r) begin
                  err_s = 1'b1;
                end else begin
                  state_s   = ST_RUNNING;
                  bounded_s = 1'b1;
                  bp_s      = cmd_arg;
                end
              end
              default: begin
                state_s = ST_HALTED;
              end
            endcase
          end
        end else begin
          state_s = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        // Start commands never disturb an active run.
        err_s = is_start_s;
        if (difftest_break) begin
          state_s = ST_HALTED;
          cause_s = CAUSE_DIFF;
          done_s  = 1'b1;
        end else if (target_hit_s) begin
          state_s = ST_HALTED;
          cause_s = CAUSE_TARGET;
          done_s  = 1'b1;
        end else if (host_halt_s) begin
          state_s = ST_HALTED;
          cause_s = CAUSE_HOST;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RUNNING;
        end
      end
      default: begin
        state_s = ST_HALTED;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_r   <= ST_HALTED;
      bounded_r <= 1'b0;
      clk_en_r  <= 1'b0;
      bp_r      <= CNT_ONES;
      cause_r   <= CAUSE_RESET;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bounded_r <= bounded_s;
      clk_en_r  <= (state_s == ST_RUNNING);
      bp_r      <= bp_s;
      cause_r   <= cause_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  // Task-cycle counter: counts every enabled cycle, including the one a stop is sampled in.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      tc_r <= CNT_ZERO;
    end else if (clk_en_r) begin
      tc_r <= tc_inc_s;
    end else begin
      tc_r <= tc_r;
    end
  end

  assign cmd_ready   = 1'b1;
  assign clk_en      = clk_en_r;
  assign running     = clk_en_r;
  assign breakpoint  = bp_r;
  assign halt_cause  = cause_r;
  assign task_cycles = tc_r;
  assign done        = done_r;
  assign cmd_err     = err_r;

endmodule

// File: tb/tb_run_ctrl_scheduler.sv
// Scoreboard bench for run_ctrl_scheduler: a run/remaining-cycles reference model
// predicts per-cycle outputs and done/err events; a monitor compares them.
module tb_run_ctrl_scheduler;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_arg;
  logic        difftest_break;
  logic        clk_en;
  logic [63:0] breakpoint;
  logic        running;
  logic [1:0]  halt_cause;
  logic [63:0] task_cycles;
  logic        done;
  logic        cmd_err;

  run_ctrl_scheduler #(.CNT_W(64)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .difftest_break(difftest_break), .clk_en(clk_en),
    .breakpoint(breakpoint), .running(running), .halt_cause(halt_cause),
    .task_cycles(task_cycles), .done(done), .cmd_err(cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          tag;
    logic        en;
    logic [63:0] tc;
    logic [63:0] bp;
    logic [1:0]  cause;
    logic        dn;
    logic        er;
  } snap_t;

  typedef struct {
    logic        is_done;
    logic [63:0] tc;
    logic [1:0]  cause;
  } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  // reference model state: running flag, bounded flag and cycles still to go
  bit          m_run, m_bnd;
  logic [63:0] m_tc, m_bp, m_rem;
  logic [1:0]  m_cause;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_bnd = 1'b0; m_tc = 64'd0; m_bp = ONES; m_rem = 64'd0; m_cause = 2'd0;
  endtask

  task automatic push_ev(bit is_done);
    ev_t e;
    e.is_done = is_done; e.tc = m_tc; e.cause = m_cause;
    ev_q.push_back(e);
  endtask

  // Applies one sampled cycle of commands to the model and queues expected outputs.
  task automatic model_step(bit v, logic [1:0] op, logic [63:0] arg, bit dt);
    snap_t s;
    bit dn = 1'b0, er = 1'b0;
    if (m_run) begin
      m_tc = m_tc + 64'd1;
      if (v && op != 2'd0) begin er = 1'b1; push_ev(1'b0); end
      if (dt || (m_bnd && m_rem == 64'd1) || (v && op == 2'd0)) begin
        m_cause = dt ? 2'd3 : ((m_bnd && m_rem == 64'd1) ? 2'd2 : 2'd1);
        m_run = 1'b0; dn = 1'b1; push_ev(1'b1);
      end else if (m_bnd) begin
        m_rem = m_rem - 64'd1;
      end
    end else if (v && op != 2'd0) begin
      if (dt) begin
        er = 1'b1; push_ev(1'b0);
      end else if (op == 2'd1) begin
        m_run = 1'b1; m_bnd = 1'b0; m_bp = ONES;
      end else if (op == 2'd2) begin
        if (arg == 64'd0) begin dn = 1'b1; push_ev(1'b1); end
        else if (arg > ONES - m_tc) begin er = 1'b1; push_ev(1'b0); end
        else begin m_run = 1'b1; m_bnd = 1'b1; m_rem = arg; m_bp = m_tc + arg; end
      end else begin
        if (arg <= m_tc) begin er = 1'b1; push_ev(1'b0); end
        else begin m_run = 1'b1; m_bnd = 1'b1; m_rem = arg - m_tc; m_bp = arg; end
      end
    end
    s.tag = cyc + 1; s.en = m_run; s.tc = m_tc; s.bp = m_bp; s.cause = m_cause;
    s.dn = dn; s.er = er;
    snap_q.push_back(s);
  endtask

  task automatic tick(bit v, logic [1:0] op, logic [63:0] arg, bit dt);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; difftest_break = dt;
    model_step(v, op, arg, dt);
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 64'd0, 1'b0);
  endtask

  // Asserts reset between edges and checks that outputs drop without a clock.
  task automatic do_reset();
    @(negedge sys_clk); #1;
    sys_reset = 1'b1;
    cmd_valid = 1'b0; difftest_break = 1'b0;
    #1;
    chk("rst_clk_en", clk_en, 1'b0);
    chk("rst_task_cycles", task_cycles, 64'd0);
    chk("rst_halt_cause", halt_cause, 2'd0);
    chk("rst_breakpoint", breakpoint, ONES);
    chk("rst_done", done, 1'b0);
    snap_q.delete(); ev_q.delete(); model_reset();
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_reset = 1'b0;
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: compares per-cycle snapshots and pops the event queue on each pulse.
  always @(negedge sys_clk) begin
    if (!sys_reset) begin
      if (snap_q.size() > 0 && snap_q[0].tag == cyc) begin
        snap_t s;
        s = snap_q.pop_front();
        chk("clk_en", clk_en, s.en);
        chk("running", running, s.en);
        chk("task_cycles", task_cycles, s.tc);
        chk("breakpoint", breakpoint, s.bp);
        chk("halt_cause", halt_cause, s.cause);
        chk("done", done, s.dn);
        chk("cmd_err", cmd_err, s.er);
        chk("cmd_ready", cmd_ready, 1'b1);
      end
      if (cmd_err) begin
        if (ev_q.size() == 0) chk("err_unexpected", 1'b1, 1'b0);
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("err_event_kind", 1'b0, e.is_done);
        end
      end
      if (done) begin
        if (ev_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("done_event_kind", 1'b1, e.is_done);
          chk("done_event_tc", task_cycles, e.tc);
          chk("done_event_cause", halt_cause, e.cause);
        end
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [63:0] arg;
    sys_reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 64'd0; difftest_break = 1'b0;
    model_reset();
    #2;
    do_reset();
    idle(2);
    // single step of 5 from reset
    tick(1'b1, 2'd2, 64'd5, 1'b0); idle(8);
    // free run then host halt
    tick(1'b1, 2'd1, 64'd0, 1'b0); idle(9); tick(1'b1, 2'd0, 64'd0, 1'b0); idle(3);
    // difftest break during a long step, then a blocked RUN
    tick(1'b1, 2'd2, 64'd100, 1'b0); idle(39);
    tick(1'b0, 2'd0, 64'd0, 1'b1); tick(1'b1, 2'd1, 64'd0, 1'b1); idle(3);
    // run-to from 20, with a rejected target and a rejected mid-run STEP
    do_reset();
    tick(1'b1, 2'd2, 64'd20, 1'b0); idle(22);
    tick(1'b1, 2'd3, 64'd20, 1'b0); tick(1'b1, 2'd3, 64'd25, 1'b0);
    idle(2); tick(1'b1, 2'd2, 64'd3, 1'b0); idle(5);
    // difftest and target stop in the same cycle
    do_reset();
    tick(1'b1, 2'd2, 64'd3, 1'b0); idle(2); tick(1'b0, 2'd0, 64'd0, 1'b1); idle(3);
    // step zero, overflowing step, reset during a run
    tick(1'b1, 2'd2, 64'd0, 1'b0); idle(2);
    tick(1'b1, 2'd2, ONES, 1'b0); idle(2);
    tick(1'b1, 2'd1, 64'd0, 1'b0); idle(5);
    do_reset();
    idle(2);
    // randomized command mix
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        op = 2'($urandom_range(0, 3));
        case (op)
          2'd2: arg = ($urandom_range(0, 9) == 0) ? ONES - 64'($urandom_range(0, 3))
                                                 : 64'($urandom_range(0, 30));
          2'd3: begin
            arg = m_tc + 64'($urandom_range(0, 30));
            if (m_tc >= 64'd5) arg = arg - 64'd5;
          end
          default: arg = 64'($urandom);
        endcase
        tick($urandom_range(0, 7) == 0, op, arg, $urandom_range(0, 39) == 0);
      end
    end
    idle(3);
    cmd_valid = 1'b0; difftest_break = 1'b0;
    @(negedge sys_clk); #1;
    chk("snap_queue_drained", 64'(snap_q.size()), 64'd0);
    chk("event_queue_drained", 64'(ev_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl_scheduler.md
Name: run_ctrl_scheduler

Overview:
- Run-control sequencer for the gated task clock. It turns host debug commands (halt, free-run, step N, run-to cycle) into the `clk_en` enable and `breakpoint` value that drive the task-clock gating block.
- It owns the authoritative task-cycle counter and reports why the task clock stopped: host, target reached, or difftest break.
- Sits between the debug/host command interface and the clock-gating stage.

Parameters:
- CNT_W, 64, width of task-cycle counter, `cmd_arg` and `breakpoint`.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- sys_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accept; constant 1 out of reset.
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=RUN_TO.
- cmd_arg  in  CNT_W  STEP: cycle count n; RUN_TO: absolute target cycle; ignored otherwise.
- difftest_break  in  1  external mismatch break, level.
- clk_en  out  1  registered enable to the clock-gating stage.
- breakpoint  out  CNT_W  current stop target to the gating stage.
- running  out  1  equals `clk_en`.
- halt_cause  out  2  0=reset, 1=host, 2=target, 3=difftest.
- task_cycles  out  CNT_W  number of cycles with `clk_en`=1 since reset.
- done  out  1  one-cycle pulse on every RUNNING→HALTED transition.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- States: HALTED, RUNNING.
- Reset values: state=HALTED, clk_en=0, breakpoint=all-ones, halt_cause=0, task_cycles=0, done=0, cmd_err=0.
- Command acceptance: a command is accepted on any cycle with `cmd_valid`=1. Effects are registered and visible the next cycle.
- task_cycles:
  - Increments by 1 in every cycle where `clk_en`=1.
  - Wraps from all-ones to 0 only during RUN.
- HALTED + RUN:
  - clk_en=1 and breakpoint=all-ones from the next cycle.
  - Enters RUNNING.
- HALTED + STEP n:
  - n=0: no state change; `done` pulses next cycle; halt_cause unchanged.
  - task_cycles+n overflows CNT_W: rejected.
  - Otherwise: breakpoint=task_cycles+n, enters RUNNING, and clk_en is high for exactly n cycles.
- HALTED + RUN_TO t:
  - t<=task_cycles: rejected.
  - Otherwise: behaves as STEP (t−task_cycles).
- HALTED + HALT: no-op; no pulses.
- RUNNING + HALT:
  - clk_en=0 next cycle, halt_cause=1, done pulses.
  - The cycle in which HALT is accepted still counts.
- RUNNING + RUN/STEP/RUN_TO: rejected; the current run continues unaffected.
- Target stop (RUNNING):
  - Stop occurs when clk_en=1 and task_cycles+1==breakpoint, with breakpoint≠all-ones or the run mode not RUN.
  - Next cycle: clk_en=0, task_cycles==breakpoint, halt_cause=2, done pulses.
- Difftest stop (RUNNING):
  - Stop occurs when difftest_break=1.
  - Next cycle: clk_en=0, halt_cause=3, done pulses.
  - The count still includes the cycle in which the break was sampled.
- Start blocked by difftest: RUN/STEP/RUN_TO received in HALTED while difftest_break=1 is rejected.
- Stop priority when several stop events occur in the same cycle: difftest (3) > target (2) > host (1). A single `done` pulse is issued.
- Rejection: `cmd_err` pulses for 1 cycle; no other state changes.
- breakpoint: holds its value after a halt until the next accepted start command.
- Mid-operation reset: sys_reset asserted at any time forces the reset values asynchronously, with clk_en dropping immediately. Operation resumes HALTED on the first clock edge after deassertion.

Test Plan:
1. Reset, then STEP n=5 at cycle T → clk_en high cycles T+1..T+5; task_cycles=5, breakpoint=5, halt_cause=2, done pulse at T+6.
2. RUN, then HALT 10 cycles later → clk_en=0 the cycle after HALT; task_cycles=10 (HALT cycle counted); halt_cause=1; single done.
3. STEP 100; assert difftest_break on the 40th enabled cycle → clk_en=0 next cycle, task_cycles=40, halt_cause=3; a following RUN while difftest_break=1 → cmd_err pulse, state stays HALTED.
4. With task_cycles=20: RUN_TO 20 → cmd_err; RUN_TO 25 → 5 enabled cycles, task_cycles=25, halt_cause=2; STEP during that run → cmd_err, run still ends at 25.
5. STEP 3 with difftest_break rising on the 3rd enabled cycle (same cycle as target) → halt_cause=3, exactly one done pulse, task_cycles=3.
6. STEP 0 → done pulse only, clk_en stays 0. STEP with task_cycles+n overflowing CNT_W → cmd_err. sys_reset asserted mid-RUN → clk_en drops immediately, task_cycles=0, halt_cause=0.
